// File: rtl/nha_lane_array.sv
// Registered array of independent approximate/exact half-adder lanes with
// per-lane error flags and a saturating accumulated error count.
module nha_lane_array #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             approx_en,
    input  logic             clr_count,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] err_mask,
    output logic [CNT_W-1:0] err_count
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Add with clamp at all-ones; the extra top bit catches the overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] t;
        logic [CNT_W-1:0] cnt_max;
        cnt_max = '1;
        t = SUM_W'(acc) + SUM_W'(inc);
        if (t > SUM_W'(cnt_max)) begin
            return cnt_max;
        end
        return t[CNT_W-1:0];
    endfunction

    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] carry_nxt;
    logic [WIDTH-1:0] err_nxt;

    always_comb begin
        carry_nxt = a & b;
        sum_nxt   = approx_en ? (a | b) : (a ^ b);
        err_nxt   = approx_en ? (a & b) : '0;
    end

    // Stage p0: operand capture into the registered result
    logic             vld_p0;
    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH-1:0] carry_p0;
    logic [WIDTH-1:0] err_p0;
    logic [CNT_W-1:0] cnt_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            sum_p0   <= '0;
            carry_p0 <= '0;
            err_p0   <= '0;
            cnt_p0   <= '0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                sum_p0   <= sum_nxt;
                carry_p0 <= carry_nxt;
                err_p0   <= err_nxt;
            end
            // Clear wins over a same-cycle accepted beat.
            if (clr_count) begin
                cnt_p0 <= '0;
            end else if (in_valid) begin
                cnt_p0 <= sat_add(cnt_p0, popcount(err_nxt));
            end
        end
    end

    assign out_valid = vld_p0;
    assign sum       = sum_p0;
    assign carry     = carry_p0;
    assign err_mask  = err_p0;
    assign err_count = cnt_p0;

endmodule

// File: tb/tb_nha_lane_array.sv
// Directed self-checking bench for nha_lane_array: truth tables, counting,
// clear priority, saturation and approximate full-adder composition.
module tb_nha_lane_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        approx_en;
    logic        clr_count;

    logic        out_valid, s_out_valid;
    logic [7:0]  sum, carry, err_mask;
    logic [7:0]  s_sum, s_carry, s_err_mask;
    logic [15:0] err_count;
    logic [3:0]  s_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nha_lane_array #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .approx_en(approx_en), .clr_count(clr_count),
        .out_valid(out_valid), .sum(sum), .carry(carry),
        .err_mask(err_mask), .err_count(err_count)
    );

    nha_lane_array #(.WIDTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .approx_en(approx_en), .clr_count(clr_count),
        .out_valid(s_out_valid), .sum(s_sum), .carry(s_carry),
        .err_mask(s_err_mask), .err_count(s_err_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the falling edge, sample 1 time unit after the rising edge.
    task automatic beat(input logic v, input logic [7:0] av, input logic [7:0] bv,
                        input logic ap, input logic clr);
        @(negedge clk);
        in_valid  = v;
        a         = av;
        b         = bv;
        approx_en = ap;
        clr_count = clr;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_cout_tbl;
    logic [7:0] exp_sum_tbl;
    logic       fa_a, fa_b, fa_cin, s1, c1, s2, c2;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; approx_en = 1'b0; clr_count = 1'b0;
        exp_cout_tbl = 8'b1110_1000;
        exp_sum_tbl  = 8'b1111_1110;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            a         = 8'($urandom);
            b         = 8'($urandom);
            approx_en = 1'($urandom_range(0, 1));
        end
        #1;
        check_eq("rst out_valid", 64'(out_valid), 64'd0);
        check_eq("rst sum",       64'(sum),       64'd0);
        check_eq("rst carry",     64'(carry),     64'd0);
        check_eq("rst err_mask",  64'(err_mask),  64'd0);
        check_eq("rst err_count", 64'(err_count), 64'd0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("idle out_valid", 64'(out_valid), 64'd0);

        beat(1'b1, 8'b0000_1111, 8'b0011_0101, 1'b1, 1'b0);
        check_eq("apx out_valid", 64'(out_valid), 64'd1);
        check_eq("apx sum",       64'(sum),       64'b0011_1111);
        check_eq("apx carry",     64'(carry),     64'b0000_0101);
        check_eq("apx err_mask",  64'(err_mask),  64'b0000_0101);
        check_eq("apx err_count", 64'(err_count), 64'd2);

        beat(1'b0, 8'hAA, 8'h55, 1'b1, 1'b0);
        check_eq("hold out_valid", 64'(out_valid), 64'd0);
        check_eq("hold sum",       64'(sum),       64'b0011_1111);
        check_eq("hold err_count", 64'(err_count), 64'd2);

        beat(1'b1, 8'b0000_1111, 8'b0011_0101, 1'b0, 1'b0);
        check_eq("exa sum",       64'(sum),       64'b0011_1010);
        check_eq("exa carry",     64'(carry),     64'b0000_0101);
        check_eq("exa err_mask",  64'(err_mask),  64'd0);
        check_eq("exa err_count", 64'(err_count), 64'd2);

        for (int i = 1; i <= 3; i++) begin
            beat(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
            check_eq("b2b out_valid", 64'(out_valid), 64'd1);
            check_eq("b2b sum",       64'(sum),       64'hFF);
            check_eq("b2b carry",     64'(carry),     64'hFF);
            check_eq("b2b err_count", 64'(err_count), 64'(2 + 8 * i));
        end
        beat(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        check_eq("clr err_count",     64'(err_count),   64'd0);
        check_eq("clr out_valid",     64'(out_valid),   64'd1);
        check_eq("clr sum",           64'(sum),         64'hFF);
        check_eq("clr sat err_count", 64'(s_err_count), 64'd0);

        beat(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check_eq("sat cnt 1", 64'(s_err_count), 64'd8);
        check_eq("wide cnt 1", 64'(err_count),  64'd8);
        beat(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check_eq("sat cnt 2", 64'(s_err_count), 64'd15);
        beat(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check_eq("sat cnt 3", 64'(s_err_count), 64'd15);
        check_eq("wide cnt 3", 64'(err_count),  64'd24);

        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                check_eq("midrst out_valid", 64'(out_valid), 64'd0);
                check_eq("midrst sum",       64'(sum),       64'd0);
                check_eq("midrst carry",     64'(carry),     64'd0);
                check_eq("midrst err_count", 64'(err_count), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            fa_a   = 1'((i >> 2) & 1);
            fa_b   = 1'((i >> 1) & 1);
            fa_cin = 1'(i & 1);
            beat(1'b1, {7'd0, fa_a}, {7'd0, fa_b}, 1'b1, 1'b0);
            s1 = sum[0];
            c1 = carry[0];
            beat(1'b1, {7'd0, s1}, {7'd0, fa_cin}, 1'b1, 1'b0);
            s2 = sum[0];
            c2 = carry[0];
            check_eq($sformatf("fa cout %0d", i), 64'(c1 | c2), 64'(exp_cout_tbl[i]));
            check_eq($sformatf("fa sum %0d", i),  64'(s2),      64'(exp_sum_tbl[i]));
        end

        beat(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
